ysyx_22050133_lsu: RTL and testbench
====================================

Name: ysyx_22050133_lsu

Overview:
Multi-cycle load/store unit between the EX stage and data memory.
- Accepts one request at a time: address, size, signedness, store data.
- Issues one naturally-aligned 64-bit memory transaction, with a byte write mask for stores.
- Waits for the memory response, then extracts and sign- or zero-extends load data.
- Returns a single-cycle result pulse to the WB stage.
- Replaces the combinational vmem read/write path in the core's MEM step with a handshaked, stallable stage.

Parameters:
- TIMEOUT_CYC, 255: cycles allowed in REQ+WAIT before an error response is forced; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  EX presents a request
- req_ready  out  1  LSU can accept; high only in IDLE
- req_wen  in  1  1=store, 0=load
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-aligned
- req_size  in  2  0=byte, 1=half, 2=word, 3=double
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts the request
- mem_addr  out  64  {req_addr[63:3],3'b0}
- mem_wen  out  1  store request
- mem_wdata  out  64  store data shifted to lane
- mem_wmask  out  8  byte enables; 0 for loads
- mem_rvalid  in  1  response/ack (loads and stores)
- mem_rdata  in  64  read data (full aligned word)
- resp_valid  out  1  one-cycle result pulse to WB
- resp_data  out  64  extended load data; 0 for stores
- resp_err  out  1  timeout or misalignment; qualified by resp_valid

Behaviour:
- Reset: state=IDLE. req_ready=1; every other output is 0, including the captured request registers and the timeout counter. Reset taken in any state aborts the operation; mem_valid is low in the cycle after the reset edge and any late mem_rvalid is ignored.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture all req_* fields and go to REQ.
  - REQ: mem_valid=1, with mem_addr/mem_wen/mem_wdata/mem_wmask stable. On mem_ready go to WAIT. mem_valid must not drop before mem_ready.
  - WAIT: mem_valid=0. On mem_rvalid, capture mem_rdata and go to RESP. mem_rvalid is sampled only in WAIT, so the earliest response is the cycle after mem_ready.
  - RESP: resp_valid=1 for exactly one cycle; resp_data and resp_err are registered. Then go to IDLE. There is no WB backpressure.
- Minimum latency: accept at cycle T, REQ at T+1, rvalid at T+2, resp_valid at T+3, next accept at T+4.
- Lane arithmetic: off=addr[2:0]; nbytes=1<<size.
  - Store: mem_wdata=req_wdata<<(8*off); mem_wmask=(((1<<nbytes)-1)<<off)[7:0].
  - Load: sh=mem_rdata>>(8*off), truncated to 8*nbytes bits, then sign-extended (req_unsigned=0) or zero-extended to 64. Size 3 needs no extension.
- Timeout:
  - The counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When count==TIMEOUT_CYC-1 and the awaited event is absent, go to RESP with resp_err=1 and resp_data=0.
  - If mem_rvalid arrives in the same cycle as the limit, it wins (normal response).
- mem_rvalid in IDLE/REQ/RESP is ignored.
- req_valid is ignored outside IDLE; EX must hold the request until req_ready.

Optional Feature:
MISALIGN_CHECK_EN
- Defined:
  - A request with addr&(nbytes-1)!=0 is accepted but not issued.
  - IDLE goes directly to RESP: resp_valid at T+1, resp_err=1, resp_data=0.
  - mem_valid never rises for that request.
- Undefined:
  - Misaligned requests are issued normally.
  - Bytes beyond the 8-byte word are dropped: the store mask is truncated and load upper bytes read as zero before extension.
  - resp_err is only ever set by timeout.

Test Plan:
1. Signed word load: addr=0x80000004, size=2, unsigned=0; mem_rdata=0x8000_0001_1234_5678 -> mem_addr=0x80000000, wmask=0; resp_data=0xFFFF_FFFF_8000_0001, resp_valid at T+3.
2. Byte load zero-extend: addr=0x...7, size=0, unsigned=1; rdata=0xAB00_..._00 -> resp_data=0xAB. Repeat with unsigned=0 -> 0xFFFF_FFFF_FFFF_FFAB.
3. Halfword store: addr=0x...2, wdata=0xBEEF -> mem_wen=1, wmask=0x0C, mem_wdata=0x0000_0000_BEEF_0000. After rvalid: resp_data=0, resp_err=0.
4. Backpressure: mem_ready low for 3 cycles -> mem_valid and all mem_* outputs held constant for 4 cycles; req_ready=0 throughout; a second req_valid is not accepted until the cycle after resp_valid.
5. Timeout (TIMEOUT_CYC=8): mem_ready=1, no rvalid -> resp_valid with resp_err=1 after 8 REQ/WAIT cycles. A late rvalid in IDLE produces no response.
6. rst asserted in WAIT -> next cycle IDLE, req_ready=1, resp_valid=0. With MISALIGN_CHECK_EN: word load at addr=0x...2 -> resp_err=1 at T+1, mem_valid never high.

Source files
------------

// File: rtl/ysyx_22050133_lsu.sv
// ysyx_22050133_lsu: multi-cycle load/store unit between EX and data memory.
// Accepts one request at a time and issues one aligned 64-bit transaction.
// It then waits for the memory response and returns a one-cycle result to WB.
// Optional build macro: MISALIGN_CHECK_EN. When defined, a misaligned request
// is answered with an error and is never issued to memory.
module ysyx_22050133_lsu #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   // EX-side request
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   // memory request channel
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [63:0] mem_addr,
   output logic        mem_wen,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   // memory response channel
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata,
   // WB-side result
   output logic        resp_valid,
   output logic [63:0] resp_data,
   output logic        resp_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]  r_state;
   logic [63:0] r_mem_addr;
   logic        r_mem_wen;
   logic [63:0] r_mem_wdata;
   logic [7:0]  r_mem_wmask;
   logic [2:0]  r_off;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [31:0] r_cnt;
   logic [63:0] r_resp_data;
   logic        r_resp_err;

   logic        w_accept;
   logic        w_limit;
   logic [7:0]  w_bmask;
   logic [7:0]  w_st_wmask;
   logic [63:0] w_st_wdata;
   logic [63:0] w_ld_shifted;
   logic [63:0] w_ld_ext;
`ifdef MISALIGN_CHECK_EN
   logic [2:0]  w_align;
   logic        w_misalign;
`endif

   assign req_ready  = (r_state == S_IDLE);
   assign w_accept   = req_valid && req_ready;

   assign mem_valid  = (r_state == S_REQ);
   assign mem_addr   = r_mem_addr;
   assign mem_wen    = r_mem_wen;
   assign mem_wdata  = r_mem_wdata;
   assign mem_wmask  = r_mem_wmask;

   assign resp_valid = (r_state == S_RESP);
   assign resp_data  = r_resp_data;
   assign resp_err   = r_resp_err;

   // Timeout limit. Compared with >= so that a counter which has already passed
   // the limit (mem_ready arriving exactly at the limit) still times out in WAIT.
   assign w_limit = (TIMEOUT_CYC != 32'd0) && (r_cnt >= (TIMEOUT_CYC - 32'd1));

   // Store lane placement: byte-enable pattern for the size, shifted to the offset.
   always_comb begin
      w_bmask = 8'h00;
      case (req_size)
         2'd0:    w_bmask = 8'h01;
         2'd1:    w_bmask = 8'h03;
         2'd2:    w_bmask = 8'h0F;
         default: w_bmask = 8'hFF;
      endcase
      // 8-bit shift drops enables for bytes past the aligned word
      w_st_wmask = req_wen ? (w_bmask << req_addr[2:0]) : 8'h00;
      w_st_wdata = req_wdata << {req_addr[2:0], 3'b000};
   end

`ifdef MISALIGN_CHECK_EN
   // Alignment check: any offset bit below the access size marks a misaligned request.
   always_comb begin
      w_align = 3'b000;
      case (req_size)
         2'd0:    w_align = 3'b000;
         2'd1:    w_align = 3'b001;
         2'd2:    w_align = 3'b011;
         default: w_align = 3'b111;
      endcase
      w_misalign = |(req_addr[2:0] & w_align);
   end
`endif

   // Load extraction: shift the addressed lane down, then sign- or zero-extend.
   always_comb begin
      w_ld_shifted = mem_rdata >> {r_off, 3'b000};
      w_ld_ext     = '0;
      case (r_size)
         2'd0: w_ld_ext = r_unsigned ? {56'd0, w_ld_shifted[7:0]}
                                     : {{56{w_ld_shifted[7]}}, w_ld_shifted[7:0]};
         2'd1: w_ld_ext = r_unsigned ? {48'd0, w_ld_shifted[15:0]}
                                     : {{48{w_ld_shifted[15]}}, w_ld_shifted[15:0]};
         2'd2: w_ld_ext = r_unsigned ? {32'd0, w_ld_shifted[31:0]}
                                     : {{32{w_ld_shifted[31]}}, w_ld_shifted[31:0]};
         default: w_ld_ext = w_ld_shifted;
      endcase
   end

   // Control FSM with request capture, timeout counter and registered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_mem_addr  <= '0;
         r_mem_wen   <= 1'b0;
         r_mem_wdata <= '0;
         r_mem_wmask <= '0;
         r_off       <= '0;
         r_size      <= '0;
         r_unsigned  <= 1'b0;
         r_cnt       <= '0;
         r_resp_data <= '0;
         r_resp_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mem_addr  <= {req_addr[63:3], 3'b000};
                  r_mem_wen   <= req_wen;
                  r_mem_wdata <= w_st_wdata;
                  r_mem_wmask <= w_st_wmask;
                  r_off       <= req_addr[2:0];
                  r_size      <= req_size;
                  r_unsigned  <= req_unsigned;
                  r_cnt       <= '0;
                  r_resp_data <= '0;
                  r_resp_err  <= 1'b0;
`ifdef MISALIGN_CHECK_EN
                  if (w_misalign) begin
                     r_state    <= S_RESP;
                     r_resp_err <= 1'b1;
                  end else begin
                     r_state    <= S_REQ;
                  end
`else
                  r_state     <= S_REQ;
`endif
               end
            end
            S_REQ: begin
               r_cnt <= r_cnt + 32'd1;
               if (mem_ready) begin
                  r_state <= S_WAIT;
               end else if (w_limit) begin
                  r_state     <= S_RESP;
                  r_resp_data <= '0;
                  r_resp_err  <= 1'b1;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt + 32'd1;
               // a response in the same cycle as the limit takes priority
               if (mem_rvalid) begin
                  r_state     <= S_RESP;
                  r_resp_data <= r_mem_wen ? 64'd0 : w_ld_ext;
                  r_resp_err  <= 1'b0;
               end else if (w_limit) begin
                  r_state     <= S_RESP;
                  r_resp_data <= '0;
                  r_resp_err  <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_resp_data <= '0;
               r_resp_err  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22050133_lsu.sv
// tb_ysyx_22050133_lsu: randomized self-checking bench for the load/store unit.
// Expected values come from byte-level reference functions and a cycle-accurate
// handshake script. Honours MISALIGN_CHECK_EN when it is defined.
module tb_ysyx_22050133_lsu;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        mem_valid;
   logic        mem_ready;
   logic [63:0] mem_addr;
   logic        mem_wen;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        resp_valid;
   logic [63:0] resp_data;
   logic        resp_err;

   int unsigned n_chk;
   int unsigned n_fail;

   ysyx_22050133_lsu #(.TIMEOUT_CYC(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wen      (req_wen),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_addr     (mem_addr),
      .mem_wen      (mem_wen),
      .mem_wdata    (mem_wdata),
      .mem_wmask    (mem_wmask),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .resp_err     (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: load value assembled byte by byte; bytes beyond the word read as 0.
   function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [2:0] off,
                                          input logic [1:0] sz, input logic uns);
      int unsigned o = off;
      int unsigned n = 1 << sz;
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++)
         if (o + i < 8) v[8*i +: 8] = rd[8*(o+i) +: 8];
      if (!uns && n < 8 && v[8*n-1])
         for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
      return v;
   endfunction

   // Reference: store data placed so that source byte i lands in lane off+i.
   function automatic logic [63:0] m_wdata(input logic [63:0] wd, input logic [2:0] off);
      int unsigned o = off;
      logic [63:0] v = '0;
      for (int j = 0; j < 8; j++)
         if (j >= o) v[8*j +: 8] = wd[8*(j-o) +: 8];
      return v;
   endfunction

   // Reference: lane j enabled when it lies within [off, off+nbytes).
   function automatic logic [7:0] m_wmask(input logic [2:0] off, input logic [1:0] sz);
      int unsigned o = off;
      int unsigned n = 1 << sz;
      logic [7:0] v = '0;
      for (int j = 0; j < 8; j++)
         v[j] = (j >= o) && (j < o + n);
      return v;
   endfunction

   task automatic scramble_req();
      req_wen      = 1'($urandom);
      req_addr     = {$urandom, $urandom};
      req_wdata    = {$urandom, $urandom};
      req_size     = 2'($urandom_range(0, 3));
      req_unsigned = 1'($urandom);
   endtask

   // One full transaction, started at a negedge in IDLE and ending at a negedge in IDLE.
   task automatic txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [63:0] rdata, input logic [1:0] sz, input logic uns,
                      input int rdly, input int vdly, input logic hold);
      logic [63:0] e_rd;
      logic [7:0]  e_wm;
      e_rd = wen ? 64'd0 : m_load(rdata, addr[2:0], sz, uns);
      e_wm = wen ? m_wmask(addr[2:0], sz) : 8'h00;
      req_valid    = 1'b1;
      req_wen      = wen;
      req_addr     = addr;
      req_wdata    = wdata;
      req_size     = sz;
      req_unsigned = uns;
      chk("req_ready_idle", 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = hold;
      scramble_req();
`ifdef MISALIGN_CHECK_EN
      if ((addr % (64'd1 << sz)) != 64'd0) begin
         chk("mis_resp_valid", 64'(resp_valid), 64'd1);
         chk("mis_resp_err", 64'(resp_err), 64'd1);
         chk("mis_resp_data", resp_data, 64'd0);
         chk("mis_mem_valid", 64'(mem_valid), 64'd0);
         @(negedge clk);
         chk("mis_mem_valid2", 64'(mem_valid), 64'd0);
         chk("mis_resp_end", 64'(resp_valid), 64'd0);
         chk("mis_ready_back", 64'(req_ready), 64'd1);
         req_valid = 1'b0;
         return;
      end
`endif
      for (int k = 0; k <= rdly; k++) begin
         chk("req_mem_valid", 64'(mem_valid), 64'd1);
         chk("req_mem_addr", mem_addr, addr & ~64'h7);
         chk("req_mem_wen", 64'(mem_wen), 64'(wen));
         if (wen) chk("req_mem_wdata", mem_wdata, m_wdata(wdata, addr[2:0]));
         chk("req_mem_wmask", 64'(mem_wmask), 64'(e_wm));
         chk("req_busy", 64'(req_ready), 64'd0);
         chk("req_no_resp", 64'(resp_valid), 64'd0);
         mem_ready = (k == rdly);
         @(negedge clk);
      end
      mem_ready = 1'b0;
      for (int k = 0; k <= vdly; k++) begin
         chk("wait_mem_valid", 64'(mem_valid), 64'd0);
         chk("wait_no_resp", 64'(resp_valid), 64'd0);
         chk("wait_busy", 64'(req_ready), 64'd0);
         mem_rvalid = (k == vdly);
         mem_rdata  = (k == vdly) ? rdata : {$urandom, $urandom};
         @(negedge clk);
      end
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
      chk("resp_valid", 64'(resp_valid), 64'd1);
      chk("resp_data", resp_data, e_rd);
      chk("resp_err", 64'(resp_err), 64'd0);
      chk("resp_busy", 64'(req_ready), 64'd0);
      @(negedge clk);
      chk("resp_pulse_end", 64'(resp_valid), 64'd0);
      chk("ready_back", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
   endtask

   // Timeout with either no mem_ready (stuck in REQ) or no response (stuck in WAIT).
   task automatic timeout_case(input logic ready_now);
      int cyc;
      req_valid    = 1'b1;
      req_wen      = 1'b0;
      req_addr     = 64'h8000_0010;
      req_size     = 2'd3;
      req_unsigned = 1'b0;
      chk("to_req_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
      mem_ready = ready_now;
      cyc = 0;
      while (!resp_valid && cyc < 20) begin
         if (!ready_now) chk("to_hold_valid", 64'(mem_valid), 64'd1);
         cyc++;
         @(negedge clk);
      end
      chk("to_cycles", 64'(cyc), 64'd8);
      chk("to_resp_valid", 64'(resp_valid), 64'd1);
      chk("to_resp_err", 64'(resp_err), 64'd1);
      chk("to_resp_data", resp_data, 64'd0);
      mem_ready = 1'b0;
      @(negedge clk);
      chk("to_pulse_end", 64'(resp_valid), 64'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h1234_5678_9ABC_DEF0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("late_rvalid_ignored", 64'(resp_valid), 64'd0);
         chk("late_rvalid_ready", 64'(req_ready), 64'd1);
      end
      mem_rvalid = 1'b0;
   endtask

   // Reset taken mid-transaction: in REQ (in_wait=0) or in WAIT (in_wait=1).
   task automatic reset_case(input logic in_wait);
      req_valid    = 1'b1;
      req_wen      = 1'b0;
      req_addr     = 64'h8000_0020;
      req_size     = 2'd3;
      req_unsigned = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rc_in_req", 64'(mem_valid), 64'd1);
      if (in_wait) begin
         mem_ready = 1'b1;
         @(negedge clk);
         mem_ready = 1'b0;
         chk("rc_in_wait", 64'(mem_valid), 64'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rc_ready", 64'(req_ready), 64'd1);
      chk("rc_mem_valid", 64'(mem_valid), 64'd0);
      chk("rc_resp_valid", 64'(resp_valid), 64'd0);
      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("rc_late_rvalid", 64'(resp_valid), 64'd0);
      @(negedge clk);
      chk("rc_idle_resp", 64'(resp_valid), 64'd0);
      chk("rc_idle_ready", 64'(req_ready), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_chk        = 0;
      n_fail       = 0;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_wen      = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      req_size     = '0;
      req_unsigned = 1'b0;
      mem_ready    = 1'b0;
      mem_rvalid   = 1'b0;
      mem_rdata    = '0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_mem_wen", 64'(mem_wen), 64'd0);
      chk("rst_mem_wdata", mem_wdata, 64'd0);
      chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_data", resp_data, 64'd0);
      chk("rst_resp_err", 64'(resp_err), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // signed word load, minimum latency
      txn(1'b0, 64'h8000_0004, 64'd0, 64'h8000_0001_1234_5678, 2'd2, 1'b0, 0, 0, 1'b0);
      // byte load at offset 7, zero- then sign-extended
      txn(1'b0, 64'h8000_0007, 64'd0, 64'hAB00_0000_0000_0000, 2'd0, 1'b1, 0, 0, 1'b0);
      txn(1'b0, 64'h8000_0007, 64'd0, 64'hAB00_0000_0000_0000, 2'd0, 1'b0, 0, 0, 1'b0);
      // halfword store
      txn(1'b1, 64'h8000_0002, 64'h0000_0000_0000_BEEF, 64'd0, 2'd1, 1'b0, 0, 0, 1'b0);
      // memory backpressure with a competing request held on the EX side
      txn(1'b0, 64'h8000_0008, 64'd0, 64'hFEDC_BA98_7654_3210, 2'd3, 1'b0, 3, 0, 1'b1);
      // response arriving exactly at the timeout limit
      txn(1'b0, 64'h8000_0006, 64'd0, 64'h8001_0000_0000_0000, 2'd1, 1'b0, 0, 6, 1'b0);
      txn(1'b1, 64'h8000_0005, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'd3, 1'b0, 2, 4, 1'b0);
      // misaligned word load (error or truncated lane, depending on build)
      txn(1'b0, 64'h8000_0002, 64'd0, 64'h8899_AABB_CCDD_EEFF, 2'd2, 1'b0, 0, 0, 1'b0);
      timeout_case(1'b1);
      timeout_case(1'b0);
      reset_case(1'b1);
      reset_case(1'b0);

      for (int t = 0; t < 300; t++) begin
         txn(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             2'($urandom_range(0, 3)), 1'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
